// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, widths and default timing for the PLL lock sequencer.
package pll_seq_pkg;
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;
  localparam int RLK_W             = 8;
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int STABLE_CYCLES_DEF = 16;
  localparam int HOLD_CYCLES_DEF   = 8;
  localparam int DROP_CYCLES_DEF   = 3;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
endpackage

// File: rtl/bit_sync.sv
// bit_sync: N-stage single-bit synchronizer, asynchronously cleared to 0.
module bit_sync #(
  parameter int N = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] s_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) s_q <= '0;
    else          s_q <= {s_q[N-2:0], d_i};
  assign q_o = s_q[N-1];
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: filters the async PLL lock flag into a synchronously released core reset,
// a ready flag, and lock-loss supervision while the core runs.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int DROP_CYCLES   = DROP_CYCLES_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             clear_fault,
  output logic             core_reset_n,
  output logic             ready,
  output logic             lock_lost,
  output logic [RLK_W-1:0] relock_count
);
  localparam int CNT_W = $clog2(max3(STABLE_CYCLES, HOLD_CYCLES, DROP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_N   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] DROP_M1  = CNT_W'(DROP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic             locked_s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  bit_sync #(.N(SYNC_STAGES)) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  // cnt_q times STABLE/HOLD and, in RUN, the current run of unlocked cycles.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      core_reset_n <= 1'b0;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      relock_count <= '0;
    end else begin
      if (clear_fault) lock_lost <= 1'b0;
      case (state_q)
        WAIT_LOCK: begin
          core_reset_n <= 1'b0;
          ready        <= 1'b0;
          cnt_q        <= locked_s ? ONE : '0;
          state_q      <= locked_s ? STABLE : WAIT_LOCK;
        end
        STABLE:
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_N) begin
            state_q <= HOLD;
            cnt_q   <= ONE;
          end else cnt_q <= cnt_q + ONE;
        HOLD:
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_N) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            core_reset_n <= 1'b1;
            ready        <= 1'b1;
          end else cnt_q <= cnt_q + ONE;
        RUN:
          if (locked_s) cnt_q <= '0;
          else if (cnt_q == DROP_M1) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            core_reset_n <= 1'b0;
            ready        <= 1'b0;
            lock_lost    <= 1'b1;
            relock_count <= &relock_count ? relock_count : relock_count + 8'd1;
          end else cnt_q <= cnt_q + ONE;
        default: begin
          state_q      <= WAIT_LOCK;
          cnt_q        <= '0;
          core_reset_n <= 1'b0;
          ready        <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: segment table plus corner sequences, checked every cycle against
// a lock-history scoreboard model and at segment ends against fixed expectations.
module tb_pll_lock_sequencer;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b1;
  logic       clear_fault = 1'b0;
  logic       core_reset_n, ready, lock_lost;
  logic [7:0] relock_count;

  int errors = 0;
  int checks = 0;

  localparam int RELEASE_RUN = 16 + 8 + 1;
  localparam int DROP_RUN    = 3;

  typedef struct {
    bit rdy;
    bit ll;
    int rc;
  } exp_t;
  exp_t sb[$];

  bit [1:0] pipe;
  bit       rel, m_ll;
  int       hi_run, lo_run, m_rc;

  typedef struct {
    bit locked;
    bit clr;
    int n;
    bit rdy;
    bit ll;
    int rc;
  } seg_t;
  seg_t segs[18];

  pll_lock_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .clear_fault (clear_fault),
    .core_reset_n(core_reset_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .relock_count(relock_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe = '0; rel = 0; m_ll = 0; hi_run = 0; lo_run = 0; m_rc = 0;
  endtask

  task automatic model_edge(input bit l, input bit c);
    bit ls, drop;
    exp_t e;
    ls = pipe[1];
    pipe = {pipe[0], l};
    drop = 0;
    if (!rel) begin
      hi_run = ls ? hi_run + 1 : 0;
      if (hi_run == RELEASE_RUN) begin rel = 1; lo_run = 0; end
    end else begin
      lo_run = ls ? 0 : lo_run + 1;
      if (lo_run == DROP_RUN) begin rel = 0; hi_run = 0; drop = 1; end
    end
    m_ll = drop ? 1'b1 : (c ? 1'b0 : m_ll);
    if (drop && m_rc < 255) m_rc++;
    e.rdy = rel; e.ll = m_ll; e.rc = m_rc;
    sb.push_back(e);
  endtask

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic step(input bit l, input bit c);
    exp_t e;
    pll_locked = l;
    clear_fault = c;
    @(posedge clock);
    model_edge(l, c);
    #1;
    e = sb.pop_front();
    check("core_reset_n", int'(core_reset_n), int'(e.rdy));
    check("ready", int'(ready), int'(e.rdy));
    check("lock_lost", int'(lock_lost), int'(e.ll));
    check("relock_count", int'(relock_count), e.rc);
    @(negedge clock);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_core_reset_n"}, int'(core_reset_n), 0);
    check({tag, "_ready"}, int'(ready), 0);
    check({tag, "_lock_lost"}, int'(lock_lost), 0);
    check({tag, "_relock_count"}, int'(relock_count), 0);
  endtask

  initial begin
    int edges;
    segs[0]  = '{1, 0, 26, 0, 0, 0};
    segs[1]  = '{1, 0, 1,  1, 0, 0};
    segs[2]  = '{1, 0, 5,  1, 0, 0};
    segs[3]  = '{0, 0, 2,  1, 0, 0};
    segs[4]  = '{1, 0, 5,  1, 0, 0};
    segs[5]  = '{0, 0, 3,  1, 0, 0};
    segs[6]  = '{1, 0, 2,  0, 1, 1};
    segs[7]  = '{1, 0, 24, 0, 1, 1};
    segs[8]  = '{1, 0, 1,  1, 1, 1};
    segs[9]  = '{1, 1, 1,  1, 0, 1};
    segs[10] = '{0, 0, 5,  0, 1, 2};
    segs[11] = '{1, 0, 10, 0, 1, 2};
    segs[12] = '{0, 0, 1,  0, 1, 2};
    segs[13] = '{1, 0, 26, 0, 1, 2};
    segs[14] = '{1, 0, 1,  1, 1, 2};
    segs[15] = '{1, 1, 1,  1, 0, 2};
    segs[16] = '{0, 0, 4,  1, 0, 2};
    segs[17] = '{0, 1, 1,  0, 1, 3};

    model_reset();
    repeat (5) begin
      @(posedge clock);
      #1 check_zero("reset");
    end
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      repeat (segs[i].n) step(segs[i].locked, segs[i].clr);
      check($sformatf("seg%0d_ready", i), int'(ready), int'(segs[i].rdy));
      check($sformatf("seg%0d_lock_lost", i), int'(lock_lost), int'(segs[i].ll));
      check($sformatf("seg%0d_relock", i), int'(relock_count), segs[i].rc);
    end

    // 254 further RUN lock losses push relock_count past 255.
    for (int k = 0; k < 254; k++) begin
      repeat (27) step(1, 0);
      check("sat_ready_back", int'(ready), 1);
      repeat (5) step(0, 0);
    end
    check("relock_saturated", int'(relock_count), 255);
    repeat (27) step(1, 0);
    check("sat_final_ready", int'(ready), 1);
    check("sat_final_relock", int'(relock_count), 255);

    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;

    edges = 0;
    while (!core_reset_n && edges < 60) begin
      step(1, 0);
      edges++;
    end
    check("post_reset_latency", edges, 27);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
